// File: rtl/gp_register_file_pkg.sv
// ----------------------------------------------------------------------------
// gp_register_file_pkg
// Shared constants for the general-purpose register file, so that decode,
// the register file and the ALU operand latches agree on word width, register
// count and whether R0 is hardwired to zero.
//
// Contents:
//   WORD_WIDTH        data word width in bits
//   NUM_GPR           number of general-purpose registers
//   GPR_AW            register address width
//   ZERO_REG_DEFAULT  1 = R0 reads as zero and ignores writes/marks
//   addrIsValid()     true when an address names a writable, readable register
// ----------------------------------------------------------------------------
package gp_register_file_pkg;

    localparam int WORD_WIDTH       = 20;
    localparam int NUM_GPR          = 8;
    localparam int GPR_AW           = $clog2(NUM_GPR);
    localparam bit ZERO_REG_DEFAULT = 1'b1;

    // An address is usable when it falls inside the file and is not the
    // hardwired zero register. Writes, busy-marks and reads all share this rule.
    function automatic logic addrIsValid(input int unsigned addr,
                                         input int unsigned depth,
                                         input bit          zeroReg);
        return (addr < depth) && !(zeroReg && (addr == 0));
    endfunction

endpackage

// File: rtl/gp_register_file_read_port.sv
// ----------------------------------------------------------------------------
// gp_register_file_read_port
// One registered read port of the register file. Looks up the addressed
// register and its busy flag, folding in a same-cycle write and busy-mark so
// the consumer always sees the state the file will hold after this edge.
//
// Ports:
//   clk_i       rising-edge clock
//   reset_i     synchronous active-high reset, clears the read outputs
//   re_i        read enable; outputs hold while low
//   raddr_i     register to read
//   regs_i      current register contents
//   busy_i      current busy scoreboard
//   wrValid_i   a valid write is happening this cycle
//   waddr_i     address of that write
//   wdata_i     data of that write
//   mkValid_i   a valid busy-mark is happening this cycle
//   markAddr_i  address of that mark
//   rdata_o     registered read data
//   busy_o      registered busy flag of the read register
// ----------------------------------------------------------------------------
module gp_register_file_read_port
    import gp_register_file_pkg::*;
#(
    parameter int WIDTH    = WORD_WIDTH,
    parameter int DEPTH    = NUM_GPR,
    parameter bit ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    input  logic [WIDTH-1:0]         regs_i [DEPTH],
    input  logic [DEPTH-1:0]         busy_i,
    input  logic                     wrValid_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     mkValid_i,
    input  logic [$clog2(DEPTH)-1:0] markAddr_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     busy_o
);

    logic             rdValid;
    logic             writeHit;
    logic             markHit;
    logic [WIDTH-1:0] rdata_d;
    logic             busy_d;
    logic [WIDTH-1:0] rdata_q;
    logic             busy_q;

    // Work out what the addressed register will look like after this edge.
    // Zero/out-of-range addresses always read as an idle zero. A same-cycle
    // mark beats a same-cycle write for busy because it names a newer producer.
    always_comb begin
        rdValid  = addrIsValid(32'(raddr_i), DEPTH, ZERO_REG);
        writeHit = wrValid_i && (waddr_i == raddr_i);
        markHit  = mkValid_i && (markAddr_i == raddr_i);
        rdata_d  = '0;
        busy_d   = 1'b0;
        if (rdValid) begin
            rdata_d = writeHit ? wdata_i : regs_i[raddr_i];
            busy_d  = markHit || (!writeHit && busy_i[raddr_i]);
        end
    end

    // Capture the lookup only when the port is enabled so the operand latch
    // downstream can rely on the value holding between reads.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else if (re_i) begin
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    assign rdata_o = rdata_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/gp_register_file.sv
// ----------------------------------------------------------------------------
// gp_register_file
// DEPTH x WIDTH general-purpose register file with one write port, two
// independently enabled registered read ports (write-to-read bypass), an
// optional hardwired-zero R0 and a per-register busy scoreboard.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   we         write enable
//   waddr      write address
//   wdata      write data
//   re_a       read enable, port A
//   raddr_a    read address, port A
//   rdata_a    registered read data, port A
//   busy_a     registered busy flag of raddr_a
//   re_b       read enable, port B
//   raddr_b    read address, port B
//   rdata_b    registered read data, port B
//   busy_b     registered busy flag of raddr_b
//   mark_busy  set the busy flag of mark_addr
//   mark_addr  register to mark busy
//   busy_vec   live scoreboard, bit n = register n busy
// ----------------------------------------------------------------------------
module gp_register_file
    import gp_register_file_pkg::*;
#(
    parameter int               WIDTH       = WORD_WIDTH,
    parameter int               DEPTH       = NUM_GPR,
    parameter bit               ZERO_REG    = ZERO_REG_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    output logic                     busy_a,
    input  logic                     re_b,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [WIDTH-1:0]         rdata_b,
    output logic                     busy_b,
    input  logic                     mark_busy,
    input  logic [$clog2(DEPTH)-1:0] mark_addr,
    output logic [DEPTH-1:0]         busy_vec
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regFile_q [DEPTH];
    logic [WIDTH-1:0] regFile_d [DEPTH];
    logic [DEPTH-1:0] busyVec_q;
    logic [DEPTH-1:0] busyVec_d;
    logic             wrValid;
    logic             mkValid;

    assign wrValid = we && addrIsValid(32'(waddr), DEPTH, ZERO_REG);
    assign mkValid = mark_busy && addrIsValid(32'(mark_addr), DEPTH, ZERO_REG);

    // Next state of storage and scoreboard. A write retires the pending
    // producer (clears busy); the mark is applied afterwards so a same-cycle
    // write+mark leaves the register busy for the newer producer.
    always_comb begin
        regFile_d = regFile_q;
        busyVec_d = busyVec_q;
        if (wrValid) begin
            regFile_d[waddr] = wdata;
            busyVec_d[waddr] = 1'b0;
        end
        if (mkValid) begin
            busyVec_d[mark_addr] = 1'b1;
        end
    end

    // Reset wins over any pending write or mark. R0 is forced to zero when
    // hardwired so it never shows RESET_VALUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile_q[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
            end
            busyVec_q <= '0;
        end else begin
            regFile_q <= regFile_d;
            busyVec_q <= busyVec_d;
        end
    end

    assign busy_vec = busyVec_q;

    gp_register_file_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG)
    ) uReadPortA (
        .clk_i     (clk),
        .reset_i   (reset),
        .re_i      (re_a),
        .raddr_i   (raddr_a),
        .regs_i    (regFile_q),
        .busy_i    (busyVec_q),
        .wrValid_i (wrValid),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .mkValid_i (mkValid),
        .markAddr_i(mark_addr),
        .rdata_o   (rdata_a),
        .busy_o    (busy_a)
    );

    gp_register_file_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG)
    ) uReadPortB (
        .clk_i     (clk),
        .reset_i   (reset),
        .re_i      (re_b),
        .raddr_i   (raddr_b),
        .regs_i    (regFile_q),
        .busy_i    (busyVec_q),
        .wrValid_i (wrValid),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .mkValid_i (mkValid),
        .markAddr_i(mark_addr),
        .rdata_o   (rdata_b),
        .busy_o    (busy_b)
    );

    // Width of the address bus is derived from DEPTH; keep AW visible for
    // readers matching it against the package's GPR_AW.
    logic [AW-1:0] unusedAddrWidthTie;
    assign unusedAddrWidthTie = waddr ^ waddr;

endmodule

// File: tb/tb_gp_register_file.sv
// ----------------------------------------------------------------------------
// tb_gp_register_file
// Self-checking bench for gp_register_file at its default parameters
// (8 x 20 bits, hardwired R0, reset value 0). A directed sequence pins key
// values with literals, then a long randomized run is checked every cycle
// against an array-based model of the register file's architectural state.
// ----------------------------------------------------------------------------
module tb_gp_register_file;
    import gp_register_file_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  we;
    logic [GPR_AW-1:0]     waddr;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  re_a;
    logic [GPR_AW-1:0]     raddr_a;
    logic [WORD_WIDTH-1:0] rdata_a;
    logic                  busy_a;
    logic                  re_b;
    logic [GPR_AW-1:0]     raddr_b;
    logic [WORD_WIDTH-1:0] rdata_b;
    logic                  busy_b;
    logic                  mark_busy;
    logic [GPR_AW-1:0]     mark_addr;
    logic [NUM_GPR-1:0]    busy_vec;

    int checks = 0;
    int errors = 0;

    gp_register_file dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re_a     (re_a),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .busy_a   (busy_a),
        .re_b     (re_b),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .busy_b   (busy_b),
        .mark_busy(mark_busy),
        .mark_addr(mark_addr),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: register contents, busy flags and the values each
    // read port should be presenting.
    int unsigned     mdlMem  [NUM_GPR];
    bit              mdlBusy [NUM_GPR];
    int unsigned     mdlRdA;
    int unsigned     mdlRdB;
    bit              mdlBusyA;
    bit              mdlBusyB;
    bit              mdlLive = 1'b0;

    function automatic bit usable(input int unsigned a);
        return (a < NUM_GPR) && (a != 0);
    endfunction

    // A read returns what the file holds once this cycle's write and mark
    // have landed, so the model applies them first and then reads.
    always @(posedge clk) begin
        int unsigned nMem  [NUM_GPR];
        bit          nBusy [NUM_GPR];
        if (reset) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                nMem[i]  = 0;
                nBusy[i] = 1'b0;
            end
            mdlMem   <= nMem;
            mdlBusy  <= nBusy;
            mdlRdA   <= 0;
            mdlRdB   <= 0;
            mdlBusyA <= 1'b0;
            mdlBusyB <= 1'b0;
            mdlLive  <= 1'b1;
        end else begin
            nMem  = mdlMem;
            nBusy = mdlBusy;
            if (we && usable(waddr)) begin
                nMem[waddr]  = wdata;
                nBusy[waddr] = 1'b0;
            end
            if (mark_busy && usable(mark_addr)) nBusy[mark_addr] = 1'b1;
            if (re_a) begin
                mdlRdA   <= usable(raddr_a) ? nMem[raddr_a] : 0;
                mdlBusyA <= usable(raddr_a) ? nBusy[raddr_a] : 1'b0;
            end
            if (re_b) begin
                mdlRdB   <= usable(raddr_b) ? nMem[raddr_b] : 0;
                mdlBusyB <= usable(raddr_b) ? nBusy[raddr_b] : 1'b0;
            end
            mdlMem  <= nMem;
            mdlBusy <= nBusy;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge, once the model has seen a reset, all outputs must
    // agree with it.
    always @(negedge clk) begin
        logic [NUM_GPR-1:0] expVec;
        if (mdlLive) begin
            for (int i = 0; i < NUM_GPR; i++) expVec[i] = mdlBusy[i];
            checkOutput("model rdata_a", 32'(rdata_a), mdlRdA);
            checkOutput("model rdata_b", 32'(rdata_b), mdlRdB);
            checkOutput("model busy_a", 32'(busy_a), 32'(mdlBusyA));
            checkOutput("model busy_b", 32'(busy_b), 32'(mdlBusyB));
            checkOutput("model busy_vec", 32'(busy_vec), 32'(expVec));
        end
    end

    // Drive one cycle of inputs just after a falling edge and return at the
    // next falling edge, when the outputs of that cycle are settled.
    task automatic applyStimulus(input logic rst, input logic weV,
                                 input logic [GPR_AW-1:0] wa, input logic [WORD_WIDTH-1:0] wd,
                                 input logic reA, input logic [GPR_AW-1:0] raA,
                                 input logic reB, input logic [GPR_AW-1:0] raB,
                                 input logic mk, input logic [GPR_AW-1:0] ma);
        reset     = rst;
        we        = weV;
        waddr     = wa;
        wdata     = wd;
        re_a      = reA;
        raddr_a   = raA;
        re_b      = reB;
        raddr_b   = raB;
        mark_busy = mk;
        mark_addr = ma;
        @(negedge clk);
    endtask

    // Hand-computed expectations for the directed scenarios, then random
    // traffic with occasional resets.
    initial begin
        $display("[TB] start");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset rdata_a", 32'(rdata_a), 32'h0);
        checkOutput("reset busy_vec", 32'(busy_vec), 32'h0);

        for (int r = 0; r < NUM_GPR; r++) begin
            applyStimulus(0, 0, 0, 0, 1, GPR_AW'(r), 1, GPR_AW'(r), 0, 0);
            checkOutput("init read a", 32'(rdata_a), 32'h0);
            checkOutput("init read b", 32'(rdata_b), 32'h0);
            checkOutput("init busy a", 32'(busy_a), 32'h0);
        end
        checkOutput("init busy_vec", 32'(busy_vec), 32'h00);

        applyStimulus(0, 1, 1, 20'h00005, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 20'h00006, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 2, 0, 0);
        checkOutput("read R1", 32'(rdata_a), 32'h00005);
        checkOutput("read R2", 32'(rdata_b), 32'h00006);
        applyStimulus(0, 0, 0, 0, 0, 3, 0, 4, 0, 0);
        checkOutput("hold a", 32'(rdata_a), 32'h00005);
        checkOutput("hold b", 32'(rdata_b), 32'h00006);

        applyStimulus(0, 1, 3, 20'hABCDE, 1, 3, 0, 0, 0, 0);
        checkOutput("bypass R3", 32'(rdata_a), 32'hABCDE);
        applyStimulus(0, 1, 0, 20'h12345, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("R0 zero", 32'(rdata_a), 32'h0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        checkOutput("mark R4 vec", 32'(busy_vec), 32'h10);
        applyStimulus(0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        checkOutput("R4 busy_a", 32'(busy_a), 32'h1);
        applyStimulus(0, 1, 4, 20'h00009, 0, 0, 0, 0, 0, 0);
        checkOutput("R4 write clears", 32'(busy_vec), 32'h00);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("mark R0 ignored", 32'(busy_vec), 32'h00);
        applyStimulus(0, 1, 5, 20'h0000A, 0, 0, 1, 5, 1, 5);
        checkOutput("R5 bypass busy", 32'(busy_b), 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        checkOutput("R5 data", 32'(rdata_a), 32'h0000A);
        checkOutput("R5 busy", 32'(busy_a), 32'h1);
        checkOutput("R5 vec", 32'(busy_vec), 32'h20);

        applyStimulus(1, 1, 6, 20'h0000B, 1, 2, 0, 0, 1, 3);
        checkOutput("reset collision rdata_a", 32'(rdata_a), 32'h0);
        checkOutput("reset collision vec", 32'(busy_vec), 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
        checkOutput("R6 after reset", 32'(rdata_a), 32'h0);
        checkOutput("vec after reset", 32'(busy_vec), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(63) == 0),
                          1'($urandom_range(1)), GPR_AW'($urandom),
                          WORD_WIDTH'($urandom),
                          1'($urandom_range(1)), GPR_AW'($urandom),
                          1'($urandom_range(1)), GPR_AW'($urandom),
                          ($urandom_range(2) == 0), GPR_AW'($urandom));
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gp_register_file.md
Name: gp_register_file

Overview:
- Parametrised successor to the single general-purpose register.
- DEPTH x WIDTH register file:
  - one write port;
  - two independently enabled read ports, registered with 1-cycle latency;
  - write-to-read bypass;
  - optional hardwired-zero R0;
  - per-register busy scoreboard for the future pipelined datapath.
- Sits between the decode stage and the ALU operand latches.

Parameters:
- WIDTH, 20, data width in bits.
- DEPTH, 8, number of registers (>=2, need not be a power of 2).
- AW, $clog2(DEPTH), address width; derived, never overridden.
- ZERO_REG, 1, 1 = register 0 reads as 0, and writes and busy-marks to it are ignored.
- RESET_VALUE, 0, value loaded into every register on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- re_a  input  1  read enable, port A.
- raddr_a  input  AW  read address, port A.
- rdata_a  output  WIDTH  registered read data, port A.
- busy_a  output  1  registered busy flag of raddr_a.
- re_b  input  1  read enable, port B.
- raddr_b  input  AW  read address, port B.
- rdata_b  output  WIDTH  registered read data, port B.
- busy_b  output  1  registered busy flag of raddr_b.
- mark_busy  input  1  set the busy flag of mark_addr.
- mark_addr  input  AW  register to mark busy.
- busy_vec  output  DEPTH  live scoreboard, bit n = register n busy.

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising clk edge.
  - Reset is synchronous, active-high, and has priority over every other input.
- Reset values:
  - All registers = RESET_VALUE.
  - rdata_a = rdata_b = 0.
  - busy_a = busy_b = 0.
  - busy_vec = 0.
  - With ZERO_REG=1, register 0 = 0 regardless of RESET_VALUE.
- Write:
  - If we=1 and waddr is valid, reg[waddr] <= wdata and busy[waddr] <= 0.
  - waddr is valid when it is < DEPTH and not (ZERO_REG and waddr==0).
  - An invalid waddr is silently ignored.
- Mark:
  - If mark_busy=1 and mark_addr is valid (same rule as waddr), busy[mark_addr] <= 1.
  - Write and mark to the same address in the same cycle: data is written and busy ends at 1 (mark wins; it represents a newer producer).
- Read, per port independently:
  - If re_x=1, on the next edge rdata_x <= value(raddr_x) and busy_x <= busy(raddr_x).
  - If re_x=0, rdata_x and busy_x hold their values.
  - Latency is exactly 1 cycle.
- Read bypass:
  - If we=1 with a valid waddr == raddr_x in the same cycle, rdata_x gets wdata (not the old contents).
  - busy_x follows the same-cycle write/mark result: 0 if write only, 1 if mark present.
  - A same-cycle mark alone (no write) also makes busy_x=1.
- Zero and out-of-range reads:
  - raddr_x==0 with ZERO_REG=1 returns 0 with busy 0.
  - raddr_x >= DEPTH returns 0 with busy 0.
- Ports A and B may read the same address simultaneously; both return identical results.
- busy_vec is the registered scoreboard state (no bypass).
- Reset asserted mid-sequence:
  - Pending write or mark in the reset cycle is discarded.
  - Read outputs go to 0 on that same edge.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package (cpu_pkg): WORD_WIDTH=20, NUM_GPR=8, GPR_AW, and the ZERO_REG default, so decode/ALU agree.
- One natural sub-module, gpr_read_port: registered read mux with bypass and busy lookup, instantiated twice (A, B).
- Storage, write logic and scoreboard stay in the top.

Test Plan:
1. Reset, then read all 8 registers on both ports with RESET_VALUE=0.
   - Expect rdata=0 and busy=0 on every read.
   - Expect busy_vec=8'h00.
2. Write 20'h00005 to R1 and 20'h00006 to R2, then re_a on R1 and re_b on R2 in one cycle.
   - Next cycle: rdata_a=20'h00005, rdata_b=20'h00006.
   - Drop re_a and re_b: both outputs hold.
3. Same-cycle we=1, waddr=3, wdata=20'hABCDE with raddr_a=3, re_a=1.
   - Next cycle: rdata_a=20'hABCDE (bypass).
   - Write 20'h12345 to R0 with ZERO_REG=1; a later read of R0 returns 0.
4. Scoreboard basic:
   - mark_busy on R4 -> busy_vec=8'h10.
   - Read R4 -> busy_a=1.
   - Write R4=20'h00009 -> busy_vec=8'h00.
5. Scoreboard corner cases:
   - Same-cycle write and mark to R5 -> R5 reads 20'h0000A with busy=1.
   - Mark R0 -> busy_vec stays 0.
6. Reset collision: assert reset in the same cycle as we=1 to R6 (20'h0000B) and re_a on R2.
   - Next cycle: rdata_a=0.
   - R6 reads 0 afterwards.
   - busy_vec=0.
